dac_spi_tx: RTL and testbench

- Downstream stage of the echo/filter datapath.
- Takes each 10-bit offset-binary sample produced on the sysclk domain and serialises it as a 16-bit SPI write frame to an MCP4911-class 10-bit DAC.
- Pulses LDAC after each frame to update the DAC output.
- Provides a one-deep pending buffer so a sample arriving mid-frame is not lost.

---
 rtl/dac_pkg.sv | 35 +++
 rtl/dac_spi_tx_sck_tick_gen.sv | 41 ++++
 rtl/dac_spi_tx.sv | 162 ++++++++++++++++
 tb/tb_dac_spi_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the MCP4911-class DAC SPI transmitter: frame layout,
// sizes and the transmitter state encoding.
package dac_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 10;

    // Frame bit positions; bit 15 is always 0 (write to DAC A).
    localparam int BIT_BUF    = 14;
    localparam int BIT_GA_N   = 13;
    localparam int BIT_SHDN_N = 12;
    localparam int DATA_LSB   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              buf_en,
        input logic              ga_n,
        input logic              shdn_n,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f                      = '0;
        f[BIT_BUF]             = buf_en;
        f[BIT_GA_N]            = ga_n;
        f[BIT_SHDN_N]          = shdn_n;
        f[DATA_LSB +: DATA_W]  = data;
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_tx_sck_tick_gen.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled and emits a
// registered one-cycle tick on each wrap. Disabling clears the count.
module sck_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    always_comb begin
        wrap   = (cnt_q == LAST);
        cnt_d  = '0;
        tick_d = 1'b0;
        if (en) begin
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
            tick_d = wrap;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 10-bit offset-binary samples into 16-bit SPI write frames for an
// MCP4911-class DAC, pulses LDAC after each frame, and buffers one pending sample.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int   CLK_DIV    = 25,
    parameter logic CFG_BUF    = 1'b0,
    parameter logic CFG_GA_N   = 1'b1,
    parameter logic CFG_SHDN_N = 1'b1
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              dac_cs,
    output logic              dac_sck,
    output logic              dac_sdi,
    output logic              dac_ld,
    output logic              busy,
    output logic              overrun
);

    localparam int                 BC_W     = $clog2(FRAME_W);
    localparam logic [BC_W-1:0]    LAST_BIT = BC_W'(FRAME_W - 1);

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic                cs_q, cs_d;
    logic                sck_q, sck_d;
    logic                sdi_q, sdi_d;
    logic                ld_q, ld_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic                tick_en;
    logic [FRAME_W-1:0]  frame;

    assign tick_en = (state_q != IDLE);

    sck_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .en     (tick_en),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        cs_d         = cs_q;
        sck_d        = sck_q;
        sdi_d        = sdi_q;
        ld_d         = ld_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        frame        = build_frame(CFG_BUF, CFG_GA_N, CFG_SHDN_N,
                                   pend_valid_q ? pend_data_q : data_in);

        // A load during a frame or LDAC pulse only touches the pending slot.
        if (load && state_q != IDLE) begin
            pend_data_d  = data_in;
            pend_valid_d = 1'b1;
            if (pend_valid_q) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_valid_q || load) begin
                    shift_d      = frame;
                    cs_d         = 1'b0;
                    sdi_d        = frame[FRAME_W-1];
                    sck_d        = 1'b0;
                    busy_d       = 1'b1;
                    bit_cnt_d    = '0;
                    state_d      = SHIFT;
                    // The pending sample wins; a simultaneous load takes its slot.
                    pend_valid_d = pend_valid_q && load;
                    if (pend_valid_q && load) begin
                        pend_data_d = data_in;
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_cnt_q != LAST_BIT) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                            sdi_d     = shift_q[FRAME_W-2];
                        end else begin
                            bit_cnt_d = '0;
                            cs_d      = 1'b1;
                            sdi_d     = 1'b0;
                            ld_d      = 1'b0;
                            state_d   = LATCH;
                        end
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    ld_d    = 1'b1;
                    busy_d  = pend_valid_d;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            cs_q         <= 1'b1;
            sck_q        <= 1'b0;
            sdi_q        <= 1'b0;
            ld_q         <= 1'b1;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            cs_q         <= cs_d;
            sck_q        <= sck_d;
            sdi_q        <= sdi_d;
            ld_q         <= ld_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dac_cs  = cs_q;
    assign dac_sck = sck_q;
    assign dac_sdi = sdi_q;
    assign dac_ld  = ld_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx at CLK_DIV=2: table of single frames plus hand-written
// pending, overrun and mid-frame reset sequences, checked by an SPI monitor.
module tb_dac_spi_tx;

    localparam int CLK_DIV    = 2;
    localparam int FRAME_BUSY = 33 * CLK_DIV + 1;
    localparam int N_VEC      = 5;

    logic       sysclk  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       load    = 1'b0;
    logic [9:0] data_in = '0;
    logic       dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun;

    typedef struct {
        logic [9:0]  data;
        logic [15:0] word;
    } vec_t;

    vec_t vecs [N_VEC];

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q   [$];
    logic [15:0] word_q  [$];
    int          bits_q  [$];
    logic        ldcs_q  [$];
    int          ldw_q   [$];
    int          busyw_q [$];

    dac_spi_tx #(
        .CLK_DIV    (CLK_DIV),
        .CFG_BUF    (1'b0),
        .CFG_GA_N   (1'b1),
        .CFG_SHDN_N (1'b1)
    ) dut (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .load    (load),
        .data_in (data_in),
        .dac_cs  (dac_cs),
        .dac_sck (dac_sck),
        .dac_sdi (dac_sdi),
        .dac_ld  (dac_ld),
        .busy    (busy),
        .overrun (overrun)
    );

    // ---------------- clock / watchdog ----------------
    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- SPI / LDAC / busy monitor ----------------
    logic [15:0] mon_sh;
    int          mon_bits, ld_run, busy_run;
    logic        prev_sck, prev_cs, prev_ld, prev_busy;

    always @(negedge sysclk) begin
        if (!rst_n) begin
            mon_sh    = '0;
            mon_bits  = 0;
            ld_run    = 0;
            busy_run  = 0;
            prev_sck  = 1'b0;
            prev_cs   = 1'b1;
            prev_ld   = 1'b1;
            prev_busy = 1'b0;
        end else begin
            if (dac_sck && !prev_sck && !dac_cs) begin
                mon_sh   = {mon_sh[14:0], dac_sdi};
                mon_bits = mon_bits + 1;
            end
            if (dac_cs && !prev_cs) begin
                word_q.push_back(mon_sh);
                bits_q.push_back(mon_bits);
                ldcs_q.push_back(dac_ld);
                mon_bits = 0;
            end
            if (!dac_ld) ld_run = ld_run + 1;
            else if (!prev_ld) begin
                ldw_q.push_back(ld_run);
                ld_run = 0;
            end
            if (busy) busy_run = busy_run + 1;
            else if (prev_busy) begin
                busyw_q.push_back(busy_run);
                busy_run = 0;
            end
            prev_sck  = dac_sck;
            prev_cs   = dac_cs;
            prev_ld   = dac_ld;
            prev_busy = busy;
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic pulse_load(input logic [9:0] d);
        @(negedge sysclk);
        load    = 1'b1;
        data_in = d;
        @(negedge sysclk);
        load    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge sysclk);
            n++;
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
        repeat (3) @(negedge sysclk);
    endtask

    task automatic check_frame(input string name);
        if (word_q.size() == 0 || exp_q.size() == 0 || bits_q.size() == 0 ||
            ldcs_q.size() == 0 || ldw_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_frame: got %0d captured frames, want %0d expected frames",
                     name, word_q.size(), exp_q.size());
            return;
        end
        chk({name, "_word"},   32'(word_q.pop_front()), 32'(exp_q.pop_front()));
        chk({name, "_sck"},    32'(bits_q.pop_front()), 32'd16);
        chk({name, "_ld_cs"},  32'(ldcs_q.pop_front()), 32'd0);
        chk({name, "_ld_len"}, 32'(ldw_q.pop_front()),  32'(CLK_DIV));
    endtask

    task automatic check_busy(input string name, input int exp);
        if (busyw_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_busy: got no busy window, want %0d cycles", name, exp);
            return;
        end
        chk({name, "_busy"}, 32'(busyw_q.pop_front()), 32'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{data: 10'h2A5, word: 16'h3A94};
        vecs[1] = '{data: 10'h000, word: 16'h3000};
        vecs[2] = '{data: 10'h3FF, word: 16'h3FFC};
        vecs[3] = '{data: 10'h155, word: 16'h3554};
        vecs[4] = '{data: 10'h200, word: 16'h3800};

        // Reset held with load toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            chk("reset_out", 32'({dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun}), 32'b100100);
            load    = ~load;
            data_in = 10'($urandom_range(0, 1023));
        end
        @(negedge sysclk);
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        // Single frames, each followed by idle.
        for (int i = 0; i < N_VEC; i++) begin
            exp_q.push_back(vecs[i].word);
            pulse_load(vecs[i].data);
            chk("start_cs",   32'(dac_cs), 32'd0);
            chk("start_busy", 32'(busy),   32'd1);
            wait_idle("single");
            check_frame("single");
            check_busy("single", FRAME_BUSY);
            chk("single_ovr", 32'(overrun), 32'd0);
        end

        // Pending sample arriving mid-frame.
        exp_q.push_back(16'h3400);
        exp_q.push_back(16'h33FC);
        pulse_load(10'h100);
        repeat (18) @(negedge sysclk);
        pulse_load(10'h0FF);
        wait_idle("pend");
        check_frame("pend1");
        check_frame("pend2");
        check_busy("pend", 2 * FRAME_BUSY + 1);
        chk("pend_ovr", 32'(overrun), 32'd0);

        // Two loads during one frame: second overwrites, overrun sticks.
        exp_q.push_back(16'h3A94);
        exp_q.push_back(16'h3008);
        pulse_load(10'h2A5);
        repeat (8) @(negedge sysclk);
        pulse_load(10'h001);
        chk("ovr_before", 32'(overrun), 32'd0);
        repeat (3) @(negedge sysclk);
        pulse_load(10'h002);
        chk("ovr_set", 32'(overrun), 32'd1);
        wait_idle("ovr");
        check_frame("ovr1");
        check_frame("ovr2");
        check_busy("ovr", 2 * FRAME_BUSY + 1);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        exp_q.push_back(16'h3000);
        pulse_load(10'h000);
        wait_idle("ovr3");
        check_frame("ovr3");
        check_busy("ovr3", FRAME_BUSY);
        chk("ovr_sticky2", 32'(overrun), 32'd1);

        // Reset after the 7th SCK rising edge aborts the frame.
        begin
            int   rises = 0;
            int   n     = 0;
            logic ps    = 1'b0;
            pulse_load(10'h3FF);
            while (rises < 7 && n < 1000) begin
                @(negedge sysclk);
                if (dac_sck && !ps) rises++;
                ps = dac_sck;
                n++;
            end
            chk("mid_sck7", 32'(rises), 32'd7);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async", 32'({dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun}), 32'b100100);
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            chk("mid_rst_hold", 32'({dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun}), 32'b100100);
        end
        chk("mid_no_frame", 32'(word_q.size()), 32'd0);
        chk("mid_no_ldac",  32'(ldw_q.size()),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);
        exp_q.push_back(16'h3554);
        pulse_load(10'h155);
        wait_idle("after");
        check_frame("after");
        check_busy("after", FRAME_BUSY);
        chk("after_ovr", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
